// File: rtl/wb_arbiter.sv
// Writeback arbiter: two per-source FIFOs (ALU, LSU) merged into one
// ROB/PRF writeback port with round-robin grant on ties.
//
// Ports:
//   clk, rstn       - clock, synchronous active-low reset
//   flush_i         - drops every buffered writeback
//   alu_*_i/lsu_*_i - source handshake (done/ready) and entry fields
//   alu_ready_o/lsu_ready_o - source FIFO has room
//   wb_*_o          - granted head entry, wb_src_o 0=ALU 1=LSU
module wb_arbiter #(
  parameter int XLEN                 = 64,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int EXCEPTION_CODE_WIDTH = 4,
  parameter int BUF_DEPTH            = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush_i,
  input  logic                            alu_done_i,
  input  logic                            alu_wb_valid_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      alu_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   alu_rd_addr_i,
  input  logic [XLEN-1:0]                 alu_data_i,
  input  logic                            alu_exp_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] alu_ecause_i,
  input  logic                            lsu_done_i,
  input  logic                            lsu_wb_valid_i,
  input  logic [ROB_INDEX_WIDTH-1:0]      lsu_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0]   lsu_rd_addr_i,
  input  logic [XLEN-1:0]                 lsu_data_i,
  input  logic                            lsu_exp_i,
  input  logic [EXCEPTION_CODE_WIDTH-1:0] lsu_ecause_i,
  output logic                            alu_ready_o,
  output logic                            lsu_ready_o,
  output logic                            wb_done_o,
  output logic                            wb_valid_o,
  output logic [ROB_INDEX_WIDTH-1:0]      wb_rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]   wb_rd_addr_o,
  output logic [XLEN-1:0]                 wb_data_o,
  output logic                            wb_exp_o,
  output logic [EXCEPTION_CODE_WIDTH-1:0] wb_ecause_o,
  output logic                            wb_src_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                            wb_valid;
    logic [ROB_INDEX_WIDTH-1:0]      rob_index;
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr;
    logic [XLEN-1:0]                 data;
    logic                            exp;
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause;
  } wb_ent_t;

  wb_ent_t        alu_mem [BUF_DEPTH];
  wb_ent_t        lsu_mem [BUF_DEPTH];
  wb_ent_t        alu_in;
  wb_ent_t        lsu_in;
  wb_ent_t        alu_head;
  wb_ent_t        lsu_head;
  wb_ent_t        grant_ent;

  logic [PW-1:0]  alu_wr_ptr;
  logic [PW-1:0]  alu_rd_ptr;
  logic [CW-1:0]  alu_cnt;
  logic [PW-1:0]  lsu_wr_ptr;
  logic [PW-1:0]  lsu_rd_ptr;
  logic [CW-1:0]  lsu_cnt;

  logic           last_grant;
  logic           alu_ne;
  logic           lsu_ne;
  logic           grant_lsu;
  logic           alu_push;
  logic           lsu_push;
  logic           alu_pop;
  logic           lsu_pop;

  assign alu_in = '{alu_wb_valid_i, alu_rob_index_i,
                    alu_rd_addr_i, alu_data_i,
                    alu_exp_i, alu_ecause_i};
  assign lsu_in = '{lsu_wb_valid_i, lsu_rob_index_i,
                    lsu_rd_addr_i, lsu_data_i,
                    lsu_exp_i, lsu_ecause_i};

  // Ready looks only at the registered count: a full
  // FIFO stays not-ready even in the cycle it pops.
  assign alu_ready_o = alu_cnt < CW'(BUF_DEPTH);
  assign lsu_ready_o = lsu_cnt < CW'(BUF_DEPTH);

  assign alu_push = alu_done_i && alu_ready_o && !flush_i;
  assign lsu_push = lsu_done_i && lsu_ready_o && !flush_i;

  assign alu_ne = alu_cnt != '0;
  assign lsu_ne = lsu_cnt != '0;

  // last_grant: 0 = ALU, 1 = LSU. On a tie the other one wins.
  assign grant_lsu = lsu_ne && (!alu_ne || !last_grant);
  assign wb_done_o = alu_ne || lsu_ne;
  assign alu_pop   = wb_done_o && !grant_lsu;
  assign lsu_pop   = wb_done_o && grant_lsu;

  assign alu_head = alu_mem[alu_rd_ptr];
  assign lsu_head = lsu_mem[lsu_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
    end else begin
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + PW'(1);
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + PW'(1);
      case ({alu_push, alu_pop})
        2'b10:   alu_cnt <= alu_cnt + CW'(1);
        2'b01:   alu_cnt <= alu_cnt - CW'(1);
        default: alu_cnt <= alu_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      lsu_wr_ptr <= '0;
      lsu_rd_ptr <= '0;
      lsu_cnt    <= '0;
    end else begin
      if (lsu_push) lsu_wr_ptr <= lsu_wr_ptr + PW'(1);
      if (lsu_pop)  lsu_rd_ptr <= lsu_rd_ptr + PW'(1);
      case ({lsu_push, lsu_pop})
        2'b10:   lsu_cnt <= lsu_cnt + CW'(1);
        2'b01:   lsu_cnt <= lsu_cnt - CW'(1);
        default: lsu_cnt <= lsu_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && alu_push) alu_mem[alu_wr_ptr] <= alu_in;
    if (rstn && lsu_push) lsu_mem[lsu_wr_ptr] <= lsu_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      last_grant <= 1'b1;
    end else if (wb_done_o) begin
      last_grant <= grant_lsu;
    end
  end

  always_comb begin
    grant_ent = '0;
    if (wb_done_o) begin
      grant_ent = grant_lsu ? lsu_head : alu_head;
    end
  end

  assign wb_valid_o     = grant_ent.wb_valid;
  assign wb_rob_index_o = grant_ent.rob_index;
  assign wb_rd_addr_o   = grant_ent.rd_addr;
  assign wb_data_o      = grant_ent.data;
  assign wb_exp_o       = grant_ent.exp;
  assign wb_ecause_o    = grant_ent.ecause;
  assign wb_src_o       = grant_lsu;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, then a queue
// scoreboard over streaming, flush, reset and random traffic.
module tb_wb_arbiter;

  typedef struct packed {
    logic        v;
    logic [3:0]  rob;
    logic [5:0]  rd;
    logic [63:0] data;
    logic        exp;
    logic [3:0]  ec;
  } ent_t;

  typedef struct {
    bit   rst;
    bit   ad;
    ent_t a;
    bit   ld;
    ent_t l;
    bit   x_done;
    bit   x_src;
    bit   x_ardy;
    bit   x_lrdy;
    ent_t x;
  } vec_t;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        ad = 1'b0;
  logic        ld = 1'b0;
  ent_t        a_in = '0;
  ent_t        l_in = '0;
  logic        a_rdy, l_rdy, w_done, w_valid;
  logic        w_exp, w_src;
  logic [3:0]  w_rob, w_ec;
  logic [5:0]  w_rd;
  logic [63:0] w_data;

  int   checks = 0;
  int   failures = 0;
  ent_t qa[$];
  ent_t ql[$];
  bit   m_last;
  bit   a_acc, l_acc;
  vec_t tv[10];

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rstn(rstn), .flush_i(flush),
    .alu_done_i(ad), .alu_wb_valid_i(a_in.v),
    .alu_rob_index_i(a_in.rob), .alu_rd_addr_i(a_in.rd),
    .alu_data_i(a_in.data), .alu_exp_i(a_in.exp),
    .alu_ecause_i(a_in.ec),
    .lsu_done_i(ld), .lsu_wb_valid_i(l_in.v),
    .lsu_rob_index_i(l_in.rob), .lsu_rd_addr_i(l_in.rd),
    .lsu_data_i(l_in.data), .lsu_exp_i(l_in.exp),
    .lsu_ecause_i(l_in.ec),
    .alu_ready_o(a_rdy), .lsu_ready_o(l_rdy),
    .wb_done_o(w_done), .wb_valid_o(w_valid),
    .wb_rob_index_o(w_rob), .wb_rd_addr_o(w_rd),
    .wb_data_o(w_data), .wb_exp_o(w_exp),
    .wb_ecause_o(w_ec), .wb_src_o(w_src)
  );

  function automatic ent_t e(bit v, logic [3:0] r,
                             logic [5:0] d, logic [63:0] x,
                             bit ex, logic [3:0] c);
    ent_t t;
    t = '{v, r, d, x, ex, c};
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, req);
    end
  endtask

  task automatic chk_out(string p, bit d, bit s,
                         bit ar, bit lr, ent_t x);
    chk({p, "_done"}, 64'(w_done), 64'(d));
    chk({p, "_src"}, 64'(w_src), 64'(s));
    chk({p, "_alu_rdy"}, 64'(a_rdy), 64'(ar));
    chk({p, "_lsu_rdy"}, 64'(l_rdy), 64'(lr));
    chk({p, "_valid"}, 64'(w_valid), 64'(x.v));
    chk({p, "_rob"}, 64'(w_rob), 64'(x.rob));
    chk({p, "_rd"}, 64'(w_rd), 64'(x.rd));
    chk({p, "_data"}, w_data, x.data);
    chk({p, "_exp"}, 64'(w_exp), 64'(x.exp));
    chk({p, "_ecause"}, 64'(w_ec), 64'(x.ec));
  endtask

  // One cycle against the scoreboard: compare current outputs
  // with the queue heads, then apply the edge to the queues.
  task automatic sb_cycle();
    bit   e_done, e_src, ar, lr;
    ent_t h;
    e_done = (qa.size() != 0) || (ql.size() != 0);
    e_src  = (ql.size() != 0) &&
             ((qa.size() == 0) || !m_last);
    ar = qa.size() < DEPTH;
    lr = ql.size() < DEPTH;
    h  = '0;
    if (e_done) h = e_src ? ql[0] : qa[0];
    chk_out("sb", e_done, e_src, ar, lr, h);
    a_acc = rstn && !flush && ad && ar;
    l_acc = rstn && !flush && ld && lr;
    @(posedge clk);
    if (!rstn || flush) begin
      qa.delete();
      ql.delete();
      m_last = 1'b1;
    end else begin
      if (e_done) begin
        if (e_src) void'(ql.pop_front());
        else void'(qa.pop_front());
        m_last = e_src;
      end
      if (a_acc) qa.push_back(a_in);
      if (l_acc) ql.push_back(l_in);
    end
    #1;
  endtask

  task automatic idle();
    ad = 1'b0;
    ld = 1'b0;
    a_in = '0;
    l_in = '0;
  endtask

  task automatic fill_both(logic [3:0] base);
    for (int i = 0; i < 3; i++) begin
      ad = 1'b1;
      ld = 1'b1;
      a_in = e(1, base + 4'(i), 6'(i), 64'h100 + 64'(i), 0, 0);
      l_in = e(1, base + 4'(i + 4), 6'(i + 8),
               64'h200 + 64'(i), 0, 0);
      sb_cycle();
    end
  endtask

  initial begin
    int ai, li;
    bit saw_full;
    ent_t z;
    z = '0;

    tv[0] = '{0, 1, e(1, 3, 10, 64'h55, 0, 0), 0, z,
              1, 0, 1, 1, e(1, 3, 10, 64'h55, 0, 0)};
    tv[1] = '{0, 0, z, 0, z, 0, 0, 1, 1, z};
    tv[2] = '{1, 0, z, 0, z, 0, 0, 1, 1, z};
    tv[3] = '{0, 1, e(1, 1, 4, 64'h1111, 0, 0),
              1, e(1, 2, 5, 64'h2222, 0, 0),
              1, 0, 1, 1, e(1, 1, 4, 64'h1111, 0, 0)};
    tv[4] = '{0, 0, z, 0, z,
              1, 1, 1, 1, e(1, 2, 5, 64'h2222, 0, 0)};
    tv[5] = '{0, 0, z, 0, z, 0, 0, 1, 1, z};
    tv[6] = '{0, 1, e(0, 5, 7, 64'h77, 1, 4), 0, z,
              1, 0, 1, 1, e(0, 5, 7, 64'h77, 1, 4)};
    tv[7] = '{0, 0, z, 0, z, 0, 0, 1, 1, z};
    tv[8] = '{0, 0, z, 1, e(1, 7, 9, 64'hAA, 0, 0),
              1, 1, 1, 1, e(1, 7, 9, 64'hAA, 0, 0)};
    tv[9] = '{0, 0, z, 0, z, 0, 0, 1, 1, z};

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 1, 1, z);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rstn = !tv[i].rst;
      ad = tv[i].ad;
      a_in = tv[i].a;
      ld = tv[i].ld;
      l_in = tv[i].l;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      idle();
      chk_out($sformatf("vec%0d", i), tv[i].x_done,
              tv[i].x_src, tv[i].x_ardy, tv[i].x_lrdy,
              tv[i].x);
    end

    rstn = 1'b0;
    sb_cycle();
    rstn = 1'b1;

    ai = 0;
    li = 0;
    saw_full = 0;
    for (int c = 0; c < 12; c++) begin
      ad = 1'b1;
      a_in = e(1, 4'(ai), 6'(ai), 64'hA000 + 64'(ai), 0, 0);
      ld = li < 3;
      l_in = e(1, 4'(li + 8), 6'(li + 32),
               64'hB000 + 64'(li), 0, 0);
      if (ld && !l_rdy) saw_full = 1;
      sb_cycle();
      if (a_acc) ai++;
      if (l_acc) li++;
    end
    idle();
    repeat (8) sb_cycle();
    chk("stream_lsu_full_seen", 64'(saw_full), 1);
    chk("stream_lsu_sent", 64'(li), 3);
    chk("stream_drained", 64'(qa.size() + ql.size()), 0);

    fill_both(4'h1);
    ad = 1'b1;
    ld = 1'b1;
    a_in = e(1, 4'hF, 6'h3F, 64'hDEAD, 0, 0);
    l_in = e(1, 4'hE, 6'h3E, 64'hBEEF, 0, 0);
    flush = 1'b1;
    sb_cycle();
    flush = 1'b0;
    idle();
    chk_out("flush_next", 0, 0, 1, 1, z);
    repeat (3) sb_cycle();

    fill_both(4'h2);
    ad = 1'b1;
    ld = 1'b1;
    rstn = 1'b0;
    sb_cycle();
    rstn = 1'b1;
    idle();
    chk_out("rst_next", 0, 0, 1, 1, z);
    repeat (3) sb_cycle();

    for (int c = 0; c < 300; c++) begin
      ad = $urandom_range(0, 1) == 1;
      ld = $urandom_range(0, 2) != 0;
      a_in = e(1'($urandom), 4'($urandom), 6'($urandom),
               {$urandom, $urandom}, 1'($urandom),
               4'($urandom));
      l_in = e(1'($urandom), 4'($urandom), 6'($urandom),
               {$urandom, $urandom}, 1'($urandom),
               4'($urandom));
      flush = $urandom_range(0, 31) == 0;
      sb_cycle();
      flush = 1'b0;
    end
    idle();
    repeat (6) sb_cycle();
    chk("rand_drained", 64'(qa.size() + ql.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter PHY_REG_ADDR_WIDTH, default 6, physical rd address width.
REQ-003 SHALL have parameter ROB_INDEX_WIDTH, default 4, ROB line index width.
REQ-004 SHALL have parameter EXCEPTION_CODE_WIDTH, default 4, ecause width.
REQ-005 SHALL have parameter BUF_DEPTH, default 2, per-source FIFO depth, power of two, >= 2.
REQ-006 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-008 SHALL have port flush_i, input, 1, trap flush; discards all buffered writebacks.
REQ-009 SHALL have ports alu_done_i / lsu_done_i, input, 1 each, a source presents a completed instruction.
REQ-010 SHALL have ports alu_wb_valid_i / lsu_wb_valid_i, input, 1 each, the instruction writes a register.
REQ-011 SHALL have ports alu_rob_index_i / lsu_rob_index_i, input, ROB_INDEX_WIDTH each, ROB line.
REQ-012 SHALL have ports alu_rd_addr_i / lsu_rd_addr_i, input, PHY_REG_ADDR_WIDTH each, destination physical register.
REQ-013 SHALL have ports alu_data_i / lsu_data_i, input, XLEN each, writeback data.
REQ-014 SHALL have ports alu_exp_i / lsu_exp_i (1) and alu_ecause_i / lsu_ecause_i (EXCEPTION_CODE_WIDTH), input, exception flag and cause.
REQ-015 SHALL have ports alu_ready_o / lsu_ready_o, output, 1 each, the source FIFO can accept an entry.
REQ-016 SHALL have port wb_done_o, output, 1, one writeback presented to ROB/PRF this cycle.
REQ-017 SHALL have ports wb_valid_o (1), wb_rob_index_o, wb_rd_addr_o, wb_data_o, wb_exp_o (1), wb_ecause_o, output, the granted entry's fields.
REQ-018 SHALL have port wb_src_o, output, 1, granted source: 0 = ALU, 1 = LSU.

Function
REQ-019 Each source SHALL own a BUF_DEPTH-entry FIFO: read/write pointers of log2(BUF_DEPTH) bits wrapping modulo BUF_DEPTH, and a count of log2(BUF_DEPTH)+1 bits.
REQ-020 A source push SHALL occur at the clock edge when done_i && ready_o; the entry stores {wb_valid, rob_index, rd_addr, data, exp, ecause}.
REQ-021 done_i while ready_o = 0 SHALL be ignored with no state change; sources hold their request until ready.
REQ-022 ready_o SHALL equal (count < BUF_DEPTH) and depend only on registered count.
- A full FIFO deasserts ready even when it pops that cycle; there is no full-pass-through.
REQ-023 Outputs SHALL be combinational from the granted FIFO head; the minimum push-to-output latency is 1 cycle.
- There is no same-cycle bypass.
REQ-024 Grant: only one FIFO non-empty -> that FIFO wins. Both non-empty -> the source not granted last wins (round-robin via a 1-bit last_grant register).
REQ-025 Both FIFOs empty SHALL give wb_done_o = 0, wb_valid_o = 0, wb_exp_o = 0, and all other outputs 0.
REQ-026 The granted head SHALL pop at the clock edge of the cycle it is presented; the downstream always accepts, so there is no backpressure.
REQ-027 wb_valid_o SHALL equal the stored wb_valid of the granted entry, ANDed with wb_done_o.
REQ-028 Simultaneous push and pop on the same FIFO SHALL leave count unchanged, with both pointers advancing.
REQ-029 last_grant SHALL update only when wb_done_o = 1.
REQ-030 flush_i = 1 SHALL, at the edge, clear both FIFOs' counts and pointers and set last_grant to LSU.
- Pushes in the flush cycle are dropped.
- Outputs in the flush cycle are still driven from the heads but carry no meaning.
- Outputs go to 0 the next cycle.
REQ-031 An exception entry (exp = 1) SHALL be arbitrated identically to normal entries; this block does no exception filtering.
REQ-032 Per-source order SHALL be preserved. Cross-source order is not guaranteed.

Reset
REQ-033 With rstn = 0 at an edge: both counts and pointers SHALL be 0, last_grant SHALL be LSU (so ALU wins the first tie), and all outputs SHALL read 0 except ready_o = 1 the following cycle.
REQ-034 Reset SHALL override flush and any concurrent pushes; entries in flight are lost.

Verification
REQ-035 Single ALU done, rob 3, rd 10, data 0x55 at cycle 0 -> cycle 1: wb_done = 1, wb_src = 0, rob 3, rd 10, data 0x55; cycle 2: wb_done = 0.
REQ-036 ALU and LSU done together (rob 1 and rob 2) after reset -> cycle 1 grants ALU rob 1, cycle 2 grants LSU rob 2.
REQ-037 LSU done on 3 consecutive cycles while ALU streams continuously (BUF_DEPTH = 2) -> lsu_ready_o drops when count = 2; grants alternate ALU/LSU; no entry is lost or reordered within a source.
REQ-038 ALU entry with wb_valid = 0, exp = 1, ecause = 4 -> wb_done = 1, wb_valid = 0, wb_exp = 1, wb_ecause = 4.
REQ-039 Both FIFOs full, flush_i pulsed for 1 cycle with new dones present -> next cycle wb_done = 0 and both ready = 1; the dropped dones never appear.
REQ-040 rstn low mid-stream with both FIFOs holding entries -> the cycle after release all outputs are 0 and both readies are 1.
